// File: rtl/riscv_dmem_arb_if.sv
// rtl/riscv_dmem_arb_if.sv - requester-side load/store port of the data memory arbiter
// One instance per requester; master is the requester, slave is the arbiter.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_ADDR_BIT
`define DMEM_ADDR_BIT 16
`endif

interface riscv_dmem_arb_if;
   logic                      req;
   logic                      wr_en;
   logic [`DMEM_ADDR_BIT-1:0] addr;
   logic [`XLEN-1:0]          wdata;
   logic [`XLEN/8-1:0]        bsel;
   logic                      gnt;
   logic                      rvalid;
   logic [`XLEN-1:0]          rdata;
   logic                      err;

   modport master (
      output req, wr_en, addr, wdata, bsel,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, wr_en, addr, wdata, bsel,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/riscv_dmem_arb.sv
// rtl/riscv_dmem_arb.sv - core/DMA data memory arbiter with round-robin, DMA lock and 1-cycle response
// Grants are combinational; responses come from registers one cycle after the grant.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_ADDR_BIT
`define DMEM_ADDR_BIT 16
`endif

module riscv_dmem_arb #(
   parameter int P_LOCK_MAX = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rstn,
   riscv_dmem_arb_if.slave           io_core,
   riscv_dmem_arb_if.slave           io_dma,
   input  logic                      i_dma_lock,
   output logic [`DMEM_ADDR_BIT-3:0] o_dmem_addr,
   output logic [`XLEN-1:0]          o_dmem_data,
   output logic [`XLEN/8-1:0]        o_dmem_bsel,
   output logic                      o_dmem_wr_en,
   input  logic [`XLEN-1:0]          i_dmem_data
);

   localparam int LW = $clog2(P_LOCK_MAX + 1);
   localparam logic [LW-1:0] LOCK_MAX = LW'(P_LOCK_MAX);
   localparam logic [`XLEN/8-1:0] BSEL_W = '1;
   localparam logic [`XLEN/8-1:0] BSEL_H = (`XLEN/8)'(2'b11);

   logic                 r_last_dma;
   logic [LW-1:0]        r_lock_cnt;
   logic                 r_core_rvalid;
   logic                 r_core_err;
   logic [`XLEN-1:0]     r_core_rdata;
   logic                 r_dma_rvalid;
   logic                 r_dma_err;
   logic [`XLEN-1:0]     r_dma_rdata;

   logic                 w_core_gnt;
   logic                 w_dma_gnt;
   logic                 w_core_mis;
   logic                 w_dma_mis;

   function automatic logic f_misaligned(input logic [`XLEN/8-1:0] bsel, input logic [1:0] lsb);
      return ((bsel == BSEL_W) && (lsb != 2'b00)) || ((bsel == BSEL_H) && lsb[0]);
   endfunction

   assign w_core_mis = f_misaligned(io_core.bsel, io_core.addr[1:0]);
   assign w_dma_mis  = f_misaligned(io_dma.bsel, io_dma.addr[1:0]);

   // A running lock keeps DMA on top until it has taken LOCK_MAX grants in a row.
   always_comb begin
      w_core_gnt = 1'b0;
      w_dma_gnt  = 1'b0;
      if (i_rstn) begin
         if (io_core.req && io_dma.req) begin
            if (i_dma_lock && (r_lock_cnt != '0))
               w_dma_gnt = (r_lock_cnt < LOCK_MAX);
            else
               w_dma_gnt = ~r_last_dma;
            w_core_gnt = ~w_dma_gnt;
         end else begin
            w_core_gnt = io_core.req;
            w_dma_gnt  = io_dma.req;
         end
      end
   end

   always_comb begin
      o_dmem_addr  = '0;
      o_dmem_data  = '0;
      o_dmem_bsel  = '0;
      o_dmem_wr_en = 1'b0;
      if (w_dma_gnt) begin
         o_dmem_addr  = io_dma.addr[`DMEM_ADDR_BIT-1:2];
         o_dmem_data  = io_dma.wdata;
         o_dmem_bsel  = io_dma.bsel;
         o_dmem_wr_en = io_dma.wr_en & ~w_dma_mis;
      end else if (w_core_gnt) begin
         o_dmem_addr  = io_core.addr[`DMEM_ADDR_BIT-1:2];
         o_dmem_data  = io_core.wdata;
         o_dmem_bsel  = io_core.bsel;
         o_dmem_wr_en = io_core.wr_en & ~w_core_mis;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_last_dma    <= 1'b1;
         r_lock_cnt    <= '0;
         r_core_rvalid <= 1'b0;
         r_core_err    <= 1'b0;
         r_core_rdata  <= '0;
         r_dma_rvalid  <= 1'b0;
         r_dma_err     <= 1'b0;
         r_dma_rdata   <= '0;
      end else begin
         if (w_core_gnt || w_dma_gnt)
            r_last_dma <= w_dma_gnt;
         if (w_core_gnt || !i_dma_lock || !io_dma.req)
            r_lock_cnt <= '0;
         else if (w_dma_gnt && (r_lock_cnt < LOCK_MAX))
            r_lock_cnt <= r_lock_cnt + LW'(1);

         r_core_rvalid <= w_core_gnt;
         r_core_err    <= w_core_gnt & w_core_mis;
         if (w_core_gnt)
            r_core_rdata <= (io_core.wr_en || w_core_mis) ? '0 : i_dmem_data;

         r_dma_rvalid <= w_dma_gnt;
         r_dma_err    <= w_dma_gnt & w_dma_mis;
         if (w_dma_gnt)
            r_dma_rdata <= (io_dma.wr_en || w_dma_mis) ? '0 : i_dmem_data;
      end
   end

   assign io_core.gnt    = w_core_gnt;
   assign io_core.rvalid = r_core_rvalid;
   assign io_core.rdata  = r_core_rdata;
   assign io_core.err    = r_core_err;
   assign io_dma.gnt     = w_dma_gnt;
   assign io_dma.rvalid  = r_dma_rvalid;
   assign io_dma.rdata   = r_dma_rdata;
   assign io_dma.err     = r_dma_err;

endmodule

// File: tb/tb_riscv_dmem_arb.sv
// tb/tb_riscv_dmem_arb.sv - randomized bench for riscv_dmem_arb with an in-bench arbitration/memory model
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_ADDR_BIT
`define DMEM_ADDR_BIT 16
`endif

module tb_riscv_dmem_arb;
   localparam int P_LOCK_MAX = 4;
   localparam int AW = `DMEM_ADDR_BIT;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          dma_lock = 1'b0;
   logic [AW-3:0] dmem_addr;
   logic [31:0]   dmem_wdata;
   logic [31:0]   dmem_rdata;
   logic [3:0]    dmem_bsel;
   logic          dmem_wr_en;

   riscv_dmem_arb_if core_if();
   riscv_dmem_arb_if dma_if();

   riscv_dmem_arb #(.P_LOCK_MAX(P_LOCK_MAX)) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .io_core      (core_if),
      .io_dma       (dma_if),
      .i_dma_lock   (dma_lock),
      .o_dmem_addr  (dmem_addr),
      .o_dmem_data  (dmem_wdata),
      .o_dmem_bsel  (dmem_bsel),
      .o_dmem_wr_en (dmem_wr_en),
      .i_dmem_data  (dmem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

   assign dmem_rdata = mem[dmem_addr[7:0]];

   always @(posedge clk)
      if (dmem_wr_en)
         for (int b = 0; b < 4; b++)
            if (dmem_bsel[b]) mem[dmem_addr[7:0]][8*b +: 8] <= dmem_wdata[8*b +: 8];

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_mis(input logic [3:0] bsel, input logic [AW-1:0] a);
      if (bsel == 4'hF) return (a % 4) != 0;
      if (bsel == 4'h3) return (a % 2) != 0;
      return 1'b0;
   endfunction

   // Model state: who was granted last (0 core, 1 dma) and how many locked DMA grants in a row.
   int          m_last = 1;
   int          m_run = 0;
   bit          exp_crv, exp_cerr, exp_drv, exp_derr;
   logic [31:0] exp_crd, exp_drd;

   always @(negedge clk) begin
      bit          g_core, g_dma, mis, wr;
      logic [AW-1:0] a;
      logic [31:0] d, rd;
      logic [3:0]  b;
      int          w;
      if (!rstn) begin
         chk("rst_core_gnt", {31'd0, core_if.gnt}, 32'd0);
         chk("rst_dma_gnt", {31'd0, dma_if.gnt}, 32'd0);
         chk("rst_wr_en", {31'd0, dmem_wr_en}, 32'd0);
         chk("rst_core_rvalid", {31'd0, core_if.rvalid}, 32'd0);
         chk("rst_dma_rvalid", {31'd0, dma_if.rvalid}, 32'd0);
         chk("rst_core_err", {31'd0, core_if.err}, 32'd0);
         chk("rst_dma_err", {31'd0, dma_if.err}, 32'd0);
         chk("rst_core_rdata", core_if.rdata, 32'd0);
         chk("rst_dma_rdata", dma_if.rdata, 32'd0);
         m_last = 1; m_run = 0;
         exp_crv = 0; exp_cerr = 0; exp_crd = 0;
         exp_drv = 0; exp_derr = 0; exp_drd = 0;
      end else begin
         chk("core_rvalid", {31'd0, core_if.rvalid}, {31'd0, exp_crv});
         chk("core_err", {31'd0, core_if.err}, {31'd0, exp_cerr});
         chk("core_rdata", core_if.rdata, exp_crd);
         chk("dma_rvalid", {31'd0, dma_if.rvalid}, {31'd0, exp_drv});
         chk("dma_err", {31'd0, dma_if.err}, {31'd0, exp_derr});
         chk("dma_rdata", dma_if.rdata, exp_drd);

         if (core_if.req && dma_if.req) begin
            if (dma_lock && m_run > 0) g_dma = (m_run < P_LOCK_MAX);
            else g_dma = (m_last == 0);
         end else begin
            g_dma = dma_if.req;
         end
         g_core = (core_if.req || dma_if.req) && !g_dma;
         chk("core_gnt", {31'd0, core_if.gnt}, {31'd0, g_core});
         chk("dma_gnt", {31'd0, dma_if.gnt}, {31'd0, g_dma});

         a  = g_dma ? dma_if.addr  : core_if.addr;
         d  = g_dma ? dma_if.wdata : core_if.wdata;
         b  = g_dma ? dma_if.bsel  : core_if.bsel;
         wr = g_dma ? dma_if.wr_en : core_if.wr_en;
         mis = is_mis(b, a);
         rd = 32'd0;
         if (g_core || g_dma) begin
            chk("dmem_addr", 32'(dmem_addr), 32'(a / 4));
            chk("dmem_data", dmem_wdata, d);
            chk("dmem_bsel", {28'd0, dmem_bsel}, {28'd0, b});
            chk("dmem_wr_en", {31'd0, dmem_wr_en}, {31'd0, wr && !mis});
            w = int'(a[9:2]);
            if (!wr && !mis) rd = ref_mem[w];
            if (wr && !mis)
               for (int k = 0; k < 4; k++)
                  if (b[k]) ref_mem[w][8*k +: 8] = d[8*k +: 8];
         end else begin
            chk("idle_dmem", {dmem_wr_en, dmem_bsel, 27'(dmem_addr)} | dmem_wdata, 32'd0);
         end

         if (g_core) begin m_last = 0; exp_crd = rd; end
         if (g_dma)  begin m_last = 1; exp_drd = rd; end
         exp_crv = g_core; exp_cerr = g_core && mis;
         exp_drv = g_dma;  exp_derr = g_dma && mis;
         if (g_core || !dma_lock || !dma_if.req) m_run = 0;
         else if (g_dma && m_run < P_LOCK_MAX) m_run++;
      end
   end

   task automatic drive_core(input bit rq, input bit wr, input logic [AW-1:0] a,
                             input logic [31:0] d, input logic [3:0] b);
      core_if.req = rq; core_if.wr_en = wr; core_if.addr = a; core_if.wdata = d; core_if.bsel = b;
   endtask

   task automatic drive_dma(input bit rq, input bit wr, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] b);
      dma_if.req = rq; dma_if.wr_en = wr; dma_if.addr = a; dma_if.wdata = d; dma_if.bsel = b;
   endtask

   function automatic logic [3:0] rand_bsel();
      case ($urandom_range(0, 8))
         0: return 4'h1;
         1: return 4'h2;
         2: return 4'h4;
         3: return 4'h8;
         4: return 4'h3;
         5: return 4'hC;
         default: return 4'hF;
      endcase
   endfunction

   task automatic reset_pulse();
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
   endtask

   logic [31:0] old0, old1;
   bit          cg, dg;
   bit          pat019 [4] = '{1, 0, 1, 0};
   bit          pat020 [7] = '{0, 1, 1, 1, 1, 0, 1};

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[4] = 32'hDEADBEEF;
      ref_mem[4] = 32'hDEADBEEF;
      drive_core(1, 0, AW'(16'h10), 32'd0, 4'hF);
      drive_dma(1, 0, '0, 32'd0, 4'hF);
      dma_lock = 1'b0;

      // Requests held during reset must not be granted.
      @(negedge clk);
      chk("lit_rst_gnt", {30'd0, core_if.gnt, dma_if.gnt}, 32'd0);

      // Core-only load of the preloaded word.
      @(posedge clk); #1;
      rstn = 1'b1;
      drive_dma(0, 0, '0, 32'd0, 4'h0);
      @(negedge clk);
      chk("lit_load_gnt", {31'd0, core_if.gnt}, 32'd1);
      @(posedge clk); #1;
      drive_core(0, 0, '0, 32'd0, 4'h0);
      @(negedge clk);
      chk("lit_load_rvalid", {31'd0, core_if.rvalid}, 32'd1);
      chk("lit_load_rdata", core_if.rdata, 32'hDEADBEEF);

      // Misaligned word store is dropped; aligned halfword store lands.
      old0 = mem[0];
      old1 = mem[1];
      @(posedge clk); #1;
      drive_core(1, 1, AW'(16'h6), 32'h11223344, 4'hF);
      @(negedge clk);
      chk("lit_mis_gnt", {31'd0, core_if.gnt}, 32'd1);
      chk("lit_mis_wr_en", {31'd0, dmem_wr_en}, 32'd0);
      @(posedge clk); #1;
      drive_core(1, 1, AW'(16'h2), 32'hCAFE0000, 4'hC);
      @(negedge clk);
      chk("lit_mis_rvalid", {31'd0, core_if.rvalid}, 32'd1);
      chk("lit_mis_err", {31'd0, core_if.err}, 32'd1);
      chk("lit_sh_wr_en", {31'd0, dmem_wr_en}, 32'd1);
      @(posedge clk); #1;
      drive_core(0, 0, '0, 32'd0, 4'h0);
      @(negedge clk);
      chk("lit_sh_err", {31'd0, core_if.err}, 32'd0);
      chk("lit_mis_mem", mem[1], old1);
      chk("lit_sh_mem", mem[0], {16'hCAFE, old0[15:0]});

      // Continuous contention without lock alternates, core first.
      reset_pulse();
      drive_core(1, 1, AW'(16'h20), 32'hA5A5_0001, 4'hF);
      drive_dma(1, 1, AW'(16'h40), 32'h5A5A_0002, 4'hF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("lit_rr_core_gnt", {31'd0, core_if.gnt}, {31'd0, pat019[i]});
         @(posedge clk); #1;
      end
      drive_core(0, 0, '0, 32'd0, 4'h0);
      drive_dma(0, 0, '0, 32'd0, 4'h0);
      @(negedge clk);
      chk("lit_rr_mem_core", mem[8], 32'hA5A5_0001);
      chk("lit_rr_mem_dma", mem[16], 32'h5A5A_0002);

      // Locked DMA: 4 grants in a row, one core grant, then DMA again.
      reset_pulse();
      dma_lock = 1'b1;
      drive_core(1, 0, AW'(16'h30), 32'd0, 4'hF);
      drive_dma(1, 0, AW'(16'h50), 32'd0, 4'hF);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("lit_lock_dma_gnt", {31'd0, dma_if.gnt}, {31'd0, pat020[i]});
         @(posedge clk); #1;
      end
      dma_lock = 1'b0;

      // Reset right after a DMA grant drops its response; core wins first contention.
      drive_core(0, 0, '0, 32'd0, 4'h0);
      @(negedge clk);
      @(posedge clk); #1;
      drive_dma(1, 0, AW'(16'h44), 32'd0, 4'hF);
      @(negedge clk);
      chk("lit_pre_rst_dma_gnt", {31'd0, dma_if.gnt}, 32'd1);
      @(posedge clk); #1;
      rstn = 1'b0;
      drive_core(1, 0, AW'(16'h48), 32'd0, 4'hF);
      @(negedge clk);
      chk("lit_rst_dma_rvalid", {31'd0, dma_if.rvalid}, 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("lit_post_rst_dma_rvalid", {31'd0, dma_if.rvalid}, 32'd0);
      chk("lit_post_rst_core_gnt", {31'd0, core_if.gnt}, 32'd1);

      // Random traffic; ungranted requests stay stable.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         cg = core_if.gnt;
         dg = dma_if.gnt;
         @(posedge clk); #1;
         if (!core_if.req || cg)
            drive_core($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                       AW'($urandom_range(0, 1023)), $urandom, rand_bsel());
         if (!dma_if.req || dg)
            drive_dma($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      AW'($urandom_range(0, 1023)), $urandom, rand_bsel());
         if ($urandom_range(0, 7) == 0) dma_lock = ~dma_lock;
      end

      @(posedge clk); #1;
      drive_core(0, 0, '0, 32'd0, 4'h0);
      drive_dma(0, 0, '0, 32'd0, 4'h0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 256; i++)
         if (mem[i] !== ref_mem[i]) chk("final_mem", mem[i], ref_mem[i]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_dmem_arb.md
RISCV_DMEM_ARB -- requirements
Module: riscv_dmem_arb

Interface
REQ-001 SHALL take widths from riscv_configs: `XLEN = 32 (data width) and `DMEM_ADDR_BIT (byte-address width).
REQ-002 SHALL have parameter P_LOCK_MAX, default 4: maximum consecutive DMA grants while the DMA port is locked.
REQ-003 Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  i_clk       in   1                  sole clock, all state on rising edge
  i_rstn      in   1                  asynchronous, active-low reset
REQ-004 SHALL provide, per requester p in {core, dma}:
  i_<p>_req    in  1                  request valid
  i_<p>_wr_en  in  1                  1 = store, 0 = load
  i_<p>_addr   in  `DMEM_ADDR_BIT     byte address
  i_<p>_wdata  in  `XLEN              store data, already lane-aligned
  i_<p>_bsel   in  `XLEN/8            byte select (sb 0001, sh 0011, sw 1111, pre-shifted)
  o_<p>_gnt    out 1                  request accepted this cycle
  o_<p>_rvalid out 1                  response valid (load data or store ack)
  o_<p>_rdata  out `XLEN              load data, full word
  o_<p>_err    out 1                  misaligned access, qualifies rvalid
REQ-005 SHALL provide i_dma_lock  in  1: DMA requests back-to-back ownership.
REQ-006 SHALL provide the memory side:
  o_dmem_addr  out  `DMEM_ADDR_BIT-2  word address
  o_dmem_data  out  `XLEN             write data
  o_dmem_bsel  out  `XLEN/8           byte select
  o_dmem_wr_en out  1                 write enable
  i_dmem_data  in   `XLEN             combinational read data

Function
REQ-007 SHALL grant at most one requester per cycle; gnt is combinational from req and state; a request is accepted only in the cycle gnt=1, and an ungranted request SHALL be held stable by the requester.
REQ-008 Arbitration SHALL be round-robin: with both requesting and no lock active, grant goes to the port not granted most recently; the last_gnt register is updated on every grant.
REQ-009 Lock: when DMA is granted with i_dma_lock=1, DMA SHALL retain priority on following cycles while i_dma_lock=1 and i_dma_req=1, up to P_LOCK_MAX consecutive grants; lock_cnt then forces one core grant if the core is requesting.
REQ-010 lock_cnt SHALL clear when the core is granted, when i_dma_lock=0, or when i_dma_req=0.
REQ-011 Memory signals SHALL be driven combinationally from the granted port: o_dmem_addr = addr[`DMEM_ADDR_BIT-1:2]; o_dmem_wr_en = gnt & wr_en & ~misaligned; with no grant, wr_en=0 and addr/data/bsel=0.
REQ-012 Misaligned SHALL mean: bsel=1111 with addr[1:0]!=0, or bsel=0011 with addr[0]=1. Such a request is granted but SHALL NOT write memory.
REQ-013 Response latency SHALL be exactly 1 cycle: the cycle after a grant, that port's rvalid=1 for one cycle; rdata = registered i_dmem_data for loads and 0 for stores or errors; err = registered misaligned.
REQ-014 A port SHALL accept back-to-back requests (one grant per cycle, sustained throughput of 1 per cycle).
REQ-015 rvalid/rdata/err SHALL change only on clock edges; outputs of the non-responding port SHALL hold rvalid=0, err=0, and rdata unchanged.

Reset
REQ-016 While i_rstn=0: last_gnt=dma (so core wins the first contention), lock_cnt=0, all rvalid=0, err=0, rdata=0; gnt and memory write enable SHALL be 0 regardless of requests.
REQ-017 Reset asserted mid-operation SHALL drop a pending response (no rvalid after release); the first grant after release follows REQ-016 state.

Verification
REQ-018 Core-only load, addr=0x10 with mem[4]=0xDEADBEEF -> core_gnt same cycle, core_rvalid=1 and rdata=0xDEADBEEF next cycle.
REQ-019 Both ports request stores continuously after reset -> grants alternate core, dma, core, dma; each store visible in memory; each port sees rvalid one cycle after each of its grants.
REQ-020 DMA lock held with both requesting, P_LOCK_MAX=4 -> 4 consecutive dma grants, then 1 core grant, then dma again.
REQ-021 Core sw to addr=0x6 (bsel=1111) -> gnt=1, o_dmem_wr_en=0, next cycle rvalid=1, err=1, memory unchanged; sh to 0x2 -> write proceeds, err=0.
REQ-022 Reset pulse in the cycle after a dma grant -> no dma_rvalid after release; the first contended grant after release goes to core.
